// File: rtl/antirrebote_botones.sv
// ============================================================================
// Module      : antirrebote_botones
// Description : Two-channel push-button conditioner. Each raw asynchronous
//               button is synchronized with two flip-flops and debounced by
//               a four-state machine. It then produces a registered
//               single-cycle pulse per accepted press, plus a registered
//               debounced level.
//               Optional macro AUTO_REPEAT_EN: adds a per-channel hold
//               counter. The counter issues periodic repeat pulses while a
//               button stays pressed (first repeat after HOLD_CYCLES, then
//               one every REPEAT_CYCLES).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module antirrebote_botones #(
  parameter int DEB_CYCLES    = 50000,
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic boton1_in,
  input  logic boton2_in,
  output logic pulso1,
  output logic pulso2,
  output logic nivel1,
  output logic nivel2
);

  // Debounce counter width: it only has to reach DEB_CYCLES-1.
  localparam int c_CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEB_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

`ifdef AUTO_REPEAT_EN
  // The hold counter has to reach the larger of the two repeat intervals.
  localparam int c_HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int c_HOLD_W   = (c_HOLD_MAX > 2) ? $clog2(c_HOLD_MAX) : 1;
  localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [c_HOLD_W-1:0] c_REP_LAST  = c_HOLD_W'(REPEAT_CYCLES - 1);
  localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);
`endif

  // Reject configurations the confirmation logic cannot honour.
  generate
    if (DEB_CYCLES < 2 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 2) begin : g_param_check
      $error("antirrebote_botones: DEB_CYCLES must be >= 2, HOLD_CYCLES >= 1, REPEAT_CYCLES >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    SOLTADO     = 2'd0,
    CONF_PULSA  = 2'd1,
    PULSADO     = 2'd2,
    CONF_SUELTA = 2'd3
  } estado_t;

  logic [1:0] w_raw;
  logic [1:0] w_pulso;
  logic [1:0] w_nivel;

  assign w_raw  = {boton2_in, boton1_in};
  assign pulso1 = w_pulso[0];
  assign pulso2 = w_pulso[1];
  assign nivel1 = w_nivel[0];
  assign nivel2 = w_nivel[1];

  // The two channels are identical and share no state.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_canal
      logic [1:0]         r_sync;
      logic               w_s;
      estado_t            r_estado;
      logic [c_CNT_W-1:0] r_cnt;
      logic               r_pulso;
      logic               r_nivel;
      logic               w_conf_done;
      logic               w_rep_hit;

      assign w_s         = r_sync[1];
      assign w_conf_done = (r_cnt == c_CNT_LAST);
      assign w_pulso[gi] = r_pulso;
      assign w_nivel[gi] = r_nivel;

      // Two-stage synchronizer for the asynchronous raw input.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sync <= 2'b00;
        end else begin
          r_sync <= {r_sync[0], w_raw[gi]};
        end
      end

`ifdef AUTO_REPEAT_EN
      logic [c_HOLD_W-1:0] r_hcnt;
      logic                r_repitiendo;
      logic                w_accept;

      assign w_accept  = (r_estado == CONF_PULSA) && w_s && w_conf_done;
      // A repeat fires while the press is still held, after HOLD_CYCLES for
      // the first repeat and after REPEAT_CYCLES for each later one.
      assign w_rep_hit = (r_estado == PULSADO) && w_s &&
                         (r_hcnt == (r_repitiendo ? c_REP_LAST : c_HOLD_LAST));

      // Hold counter: cleared on acceptance and while released. It runs
      // while held and freezes during a release confirmation.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_hcnt       <= '0;
          r_repitiendo <= 1'b0;
        end else if (w_accept || (r_estado == SOLTADO)) begin
          r_hcnt       <= '0;
          r_repitiendo <= 1'b0;
        end else if (w_rep_hit) begin
          r_hcnt       <= '0;
          r_repitiendo <= 1'b1;
        end else if ((r_estado == PULSADO) && w_s) begin
          r_hcnt       <= r_hcnt + c_HOLD_ONE;
        end
      end
`else
      assign w_rep_hit = 1'b0;
`endif

      // Debounce state machine with registered pulse and level outputs.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_estado <= SOLTADO;
          r_cnt    <= '0;
          r_pulso  <= 1'b0;
          r_nivel  <= 1'b0;
        end else begin
          r_pulso <= 1'b0;
          case (r_estado)
            SOLTADO: begin
              r_nivel <= 1'b0;
              if (w_s) begin
                r_estado <= CONF_PULSA;
                r_cnt    <= c_CNT_ONE;
              end
            end
            CONF_PULSA: begin
              if (!w_s) begin
                r_estado <= SOLTADO;
                r_cnt    <= '0;
              end else if (w_conf_done) begin
                r_estado <= PULSADO;
                r_cnt    <= '0;
                r_pulso  <= 1'b1;
                r_nivel  <= 1'b1;
              end else begin
                r_cnt    <= r_cnt + c_CNT_ONE;
              end
            end
            PULSADO: begin
              r_nivel <= 1'b1;
              if (!w_s) begin
                r_estado <= CONF_SUELTA;
                r_cnt    <= c_CNT_ONE;
              end else begin
                r_pulso  <= w_rep_hit;
              end
            end
            CONF_SUELTA: begin
              if (w_s) begin
                r_estado <= PULSADO;
                r_cnt    <= '0;
              end else if (w_conf_done) begin
                r_estado <= SOLTADO;
                r_cnt    <= '0;
                r_nivel  <= 1'b0;
              end else begin
                r_cnt    <= r_cnt + c_CNT_ONE;
              end
            end
            default: begin
              r_estado <= SOLTADO;
              r_cnt    <= '0;
              r_nivel  <= 1'b0;
            end
          endcase
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire
